// File: rtl/draw_layer_arbiter.sv
// Purpose: fixed-priority per-pixel RGB arbiter for the VGA path, plus once-per-frame collision tracking.
// Latency: every output is registered, 1 clock after the pixel inputs.
// Backpressure: none; the pixel stream is free-running and is sampled every clock.
// Optional feature macro: TRANSPARENT_SKIP_EN (transparent sprite pixels neither draw nor collide).
module draw_layer_arbiter #(
    parameter int               NUM_OBJ           = 4,
    parameter logic [7:0]       TRANSPARENT_COLOR = 8'hFF
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    input  logic [7:0]             BG_RGB,
    input  logic                   boardersDrawReq,
    input  logic [NUM_OBJ-1:0]     objDrawReq,
    input  logic [8*NUM_OBJ-1:0]   objRGB,
    output logic [7:0]             RGBOut,
    output logic [3:0]             drawLayer,
    output logic                   startOfFrame,
    output logic [7:0]             frameCount,
    output logic [NUM_OBJ-1:0]     hitPulse,
    output logic [NUM_OBJ-1:0]     collisionMask
);

    // Layer codes beyond the object indices: border, then plain background.
    localparam logic [3:0] LAYER_BORDER = 4'(NUM_OBJ);
    localparam logic [3:0] LAYER_BG     = 4'(NUM_OBJ + 1);

    logic [NUM_OBJ-1:0] eff;
    logic [NUM_OBJ-1:0] hit;
    logic [NUM_OBJ-1:0] acc;
    logic [7:0]         win_rgb;
    logic [3:0]         win_layer;
    logic               origin;
    logic               origin_d;
    logic               sof;

`ifdef TRANSPARENT_SKIP_EN
    // Effective requests: a sprite pixel painted in the transparent colour is not there at all.
    always_comb begin
        eff = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            eff[i] = objDrawReq[i] && (objRGB[8*i +: 8] != TRANSPARENT_COLOR);
        end
    end
`else
    // Effective requests: every requested pixel is drawn, whatever its colour.
    always_comb begin
        eff = objDrawReq;
    end
`endif

    // Fixed priority: scanning from the top index down leaves the lowest asserted index as winner.
    always_comb begin
        win_rgb   = BG_RGB;
        win_layer = boardersDrawReq ? LAYER_BORDER : LAYER_BG;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (eff[i]) begin
                win_rgb   = objRGB[8*i +: 8];
                win_layer = 4'(i);
            end
        end
    end

    // Collisions: the player only collides with borders; every other object with the player or a border.
    always_comb begin
        hit    = '0;
        hit[0] = eff[0] && boardersDrawReq;
        for (int i = 1; i < NUM_OBJ; i++) begin
            hit[i] = eff[i] && (eff[0] || boardersDrawReq);
        end
    end

    // Frame start is the first cycle at the origin, so a stalled coordinate still yields one pulse.
    always_comb begin
        origin = (pixelX == 11'd0) && (pixelY == 11'd0);
        sof    = origin && !origin_d;
    end

    // Register the arbitrated pixel.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBOut    <= 8'h00;
            drawLayer <= LAYER_BG;
        end else begin
            RGBOut    <= win_rgb;
            drawLayer <= win_layer;
        end
    end

    // Frame bookkeeping: accumulate hits during the frame (ACCUM), publish them on the sof cycle (PUBLISH).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            origin_d      <= 1'b0;
            startOfFrame  <= 1'b0;
            frameCount    <= 8'h00;
            hitPulse      <= '0;
            collisionMask <= '0;
            acc           <= '0;
        end else begin
            origin_d     <= origin;
            startOfFrame <= sof;
            if (sof) begin
                // The origin pixel belongs to the new frame, so its hits seed the fresh accumulator.
                collisionMask <= acc;
                acc           <= hit;
                hitPulse      <= hit;
                frameCount    <= frameCount + 8'd1;
            end else begin
                acc      <= acc | hit;
                hitPulse <= hit & ~acc;
            end
        end
    end

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Purpose: directed self-checking bench for draw_layer_arbiter (NUM_OBJ = 4).
// Latency: outputs are checked #1 after the clock edge that registered the driven inputs.
// Backpressure: none; stimulus is a fixed per-cycle pixel sequence.
module tb_draw_layer_arbiter;

    logic        clk;
    logic        resetN;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [7:0]  BG_RGB;
    logic        boardersDrawReq;
    logic [3:0]  objDrawReq;
    logic [31:0] objRGB;
    logic [7:0]  RGBOut;
    logic [3:0]  drawLayer;
    logic        startOfFrame;
    logic [7:0]  frameCount;
    logic [3:0]  hitPulse;
    logic [3:0]  collisionMask;

    int n_cmp = 0;
    int n_err = 0;

    draw_layer_arbiter #(.NUM_OBJ(4), .TRANSPARENT_COLOR(8'hFF)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .BG_RGB         (BG_RGB),
        .boardersDrawReq(boardersDrawReq),
        .objDrawReq     (objDrawReq),
        .objRGB         (objRGB),
        .RGBOut         (RGBOut),
        .drawLayer      (drawLayer),
        .startOfFrame   (startOfFrame),
        .frameCount     (frameCount),
        .hitPulse       (hitPulse),
        .collisionMask  (collisionMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock, then settle so registered outputs are stable for checking.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
    endtask

    task automatic do_reset();
        resetN          = 1'b0;
        set_pix(5, 5);
        BG_RGB          = 8'h03;
        boardersDrawReq = 1'b0;
        objDrawReq      = 4'b0000;
        objRGB          = 32'h0;
        step();
        step();
        resetN = 1'b1;
    endtask

    task automatic test_reset();
        resetN          = 1'b0;
        set_pix(0, 0);
        BG_RGB          = 8'h5A;
        boardersDrawReq = 1'b1;
        objDrawReq      = 4'b1111;
        objRGB          = 32'h11223344;
        step();
        n_cmp++; if (RGBOut !== 8'h00)        begin n_err++; $display("FAIL reset_rgb got %h want 00", RGBOut); end
        n_cmp++; if (drawLayer !== 4'd5)      begin n_err++; $display("FAIL reset_layer got %0d want 5", drawLayer); end
        n_cmp++; if (startOfFrame !== 1'b0)   begin n_err++; $display("FAIL reset_sof got %b want 0", startOfFrame); end
        n_cmp++; if (frameCount !== 8'd0)     begin n_err++; $display("FAIL reset_fc got %0d want 0", frameCount); end
        n_cmp++; if (hitPulse !== 4'b0)       begin n_err++; $display("FAIL reset_hit got %b want 0000", hitPulse); end
        n_cmp++; if (collisionMask !== 4'b0)  begin n_err++; $display("FAIL reset_mask got %b want 0000", collisionMask); end
    endtask

    task automatic test_priority();
        do_reset();
        objDrawReq = 4'b0110;
        objRGB     = {8'h00, 8'hE0, 8'h1C, 8'h00};
        BG_RGB     = 8'h03;
        step();
        n_cmp++; if (RGBOut !== 8'h1C)   begin n_err++; $display("FAIL prio_rgb got %h want 1c", RGBOut); end
        n_cmp++; if (drawLayer !== 4'd1) begin n_err++; $display("FAIL prio_layer got %0d want 1", drawLayer); end
        n_cmp++; if (hitPulse !== 4'b0)  begin n_err++; $display("FAIL prio_nohit got %b want 0000", hitPulse); end
        objDrawReq      = 4'b0000;
        boardersDrawReq = 1'b1;
        step();
        n_cmp++; if (RGBOut !== 8'h03)   begin n_err++; $display("FAIL border_rgb got %h want 03", RGBOut); end
        n_cmp++; if (drawLayer !== 4'd4) begin n_err++; $display("FAIL border_layer got %0d want 4", drawLayer); end
        boardersDrawReq = 1'b0;
        step();
        n_cmp++; if (RGBOut !== 8'h03)   begin n_err++; $display("FAIL bg_rgb got %h want 03", RGBOut); end
        n_cmp++; if (drawLayer !== 4'd5) begin n_err++; $display("FAIL bg_layer got %0d want 5", drawLayer); end
        objDrawReq = 4'b1111;
        objRGB     = {8'hAA, 8'hBB, 8'hCC, 8'h77};
        step();
        n_cmp++; if (RGBOut !== 8'h77)   begin n_err++; $display("FAIL player_rgb got %h want 77", RGBOut); end
        n_cmp++; if (drawLayer !== 4'd0) begin n_err++; $display("FAIL player_layer got %0d want 0", drawLayer); end
        objDrawReq = 4'b1000;
        step();
        n_cmp++; if (RGBOut !== 8'hAA)   begin n_err++; $display("FAIL obj3_rgb got %h want aa", RGBOut); end
        n_cmp++; if (drawLayer !== 4'd3) begin n_err++; $display("FAIL obj3_layer got %0d want 3", drawLayer); end
        objDrawReq = 4'b0000;
    endtask

    task automatic test_frame_pulse();
        do_reset();
        for (int f = 1; f <= 3; f++) begin
            set_pix(0, 0);
            step();
            n_cmp++; if (startOfFrame !== 1'b1) begin n_err++; $display("FAIL sof_first f%0d got %b want 1", f, startOfFrame); end
            n_cmp++; if (frameCount !== 8'(f))  begin n_err++; $display("FAIL fc f%0d got %0d want %0d", f, frameCount, f); end
            for (int k = 0; k < 2; k++) begin
                step();
                n_cmp++; if (startOfFrame !== 1'b0) begin n_err++; $display("FAIL sof_held f%0d got %b want 0", f, startOfFrame); end
            end
            set_pix(1, 0);
            step();
            n_cmp++; if (startOfFrame !== 1'b0) begin n_err++; $display("FAIL sof_off f%0d got %b want 0", f, startOfFrame); end
            n_cmp++; if (frameCount !== 8'(f))  begin n_err++; $display("FAIL fc_hold f%0d got %0d want %0d", f, frameCount, f); end
        end
        for (int f = 4; f <= 255; f++) begin
            set_pix(0, 0);
            step();
            set_pix(7, 3);
            step();
        end
        n_cmp++; if (frameCount !== 8'd255) begin n_err++; $display("FAIL fc_255 got %0d want 255", frameCount); end
        set_pix(0, 0);
        step();
        n_cmp++; if (frameCount !== 8'd0)   begin n_err++; $display("FAIL fc_wrap got %0d want 0", frameCount); end
        n_cmp++; if (startOfFrame !== 1'b1) begin n_err++; $display("FAIL sof_wrap got %b want 1", startOfFrame); end
        set_pix(5, 5);
        step();
    endtask

    task automatic test_collision();
        do_reset();
        set_pix(0, 0);
        step();
        n_cmp++; if (collisionMask !== 4'b0000) begin n_err++; $display("FAIL coll_mask_n got %b want 0000", collisionMask); end
        objRGB     = {8'h00, 8'hE0, 8'h00, 8'h1C};
        objDrawReq = 4'b0101;
        for (int p = 0; p < 5; p++) begin
            set_pix(10 + p, 10);
            step();
            if (p == 0) begin
                n_cmp++; if (hitPulse !== 4'b0100) begin n_err++; $display("FAIL coll_first got %b want 0100", hitPulse); end
            end else begin
                n_cmp++; if (hitPulse !== 4'b0000) begin n_err++; $display("FAIL coll_again p%0d got %b want 0000", p, hitPulse); end
            end
            n_cmp++; if (drawLayer !== 4'd0) begin n_err++; $display("FAIL coll_layer p%0d got %0d want 0", p, drawLayer); end
        end
        objDrawReq = 4'b0000;
        set_pix(20, 10);
        step();
        n_cmp++; if (collisionMask !== 4'b0000) begin n_err++; $display("FAIL coll_mask_early got %b want 0000", collisionMask); end
        set_pix(0, 0);
        step();
        n_cmp++; if (startOfFrame !== 1'b1)     begin n_err++; $display("FAIL coll_sof got %b want 1", startOfFrame); end
        n_cmp++; if (collisionMask !== 4'b0100) begin n_err++; $display("FAIL coll_mask_n1 got %b want 0100", collisionMask); end
        n_cmp++; if (hitPulse !== 4'b0000)      begin n_err++; $display("FAIL coll_sof_hit got %b want 0000", hitPulse); end
        set_pix(30, 30);
        step();
        step();
        n_cmp++; if (collisionMask !== 4'b0100) begin n_err++; $display("FAIL coll_mask_stable got %b want 0100", collisionMask); end
        set_pix(0, 0);
        step();
        n_cmp++; if (collisionMask !== 4'b0000) begin n_err++; $display("FAIL coll_mask_n2 got %b want 0000", collisionMask); end
        set_pix(5, 5);
        step();
    endtask

    task automatic test_sof_hit();
        do_reset();
        objRGB          = {8'h00, 8'h00, 8'h00, 8'h1C};
        objDrawReq      = 4'b0001;
        boardersDrawReq = 1'b1;
        step();
        n_cmp++; if (hitPulse !== 4'b0001) begin n_err++; $display("FAIL sofhit_pre got %b want 0001", hitPulse); end
        set_pix(0, 0);
        step();
        n_cmp++; if (startOfFrame !== 1'b1)     begin n_err++; $display("FAIL sofhit_sof got %b want 1", startOfFrame); end
        n_cmp++; if (hitPulse !== 4'b0001)      begin n_err++; $display("FAIL sofhit_pulse got %b want 0001", hitPulse); end
        n_cmp++; if (collisionMask !== 4'b0001) begin n_err++; $display("FAIL sofhit_oldmask got %b want 0001", collisionMask); end
        objDrawReq      = 4'b0000;
        boardersDrawReq = 1'b0;
        set_pix(3, 3);
        step();
        n_cmp++; if (hitPulse !== 4'b0000) begin n_err++; $display("FAIL sofhit_after got %b want 0000", hitPulse); end
        set_pix(0, 0);
        step();
        n_cmp++; if (collisionMask !== 4'b0001) begin n_err++; $display("FAIL sofhit_seed got %b want 0001", collisionMask); end
        set_pix(5, 5);
        step();
    endtask

    task automatic test_transparency();
        do_reset();
        objRGB          = {8'h00, 8'h00, 8'h00, 8'hFF};
        objDrawReq      = 4'b0001;
        boardersDrawReq = 1'b1;
        BG_RGB          = 8'h03;
        step();
`ifdef TRANSPARENT_SKIP_EN
        n_cmp++; if (drawLayer !== 4'd4)   begin n_err++; $display("FAIL transp_layer got %0d want 4", drawLayer); end
        n_cmp++; if (RGBOut !== 8'h03)     begin n_err++; $display("FAIL transp_rgb got %h want 03", RGBOut); end
        n_cmp++; if (hitPulse !== 4'b0000) begin n_err++; $display("FAIL transp_hit got %b want 0000", hitPulse); end
`else
        n_cmp++; if (drawLayer !== 4'd0)   begin n_err++; $display("FAIL transp_layer got %0d want 0", drawLayer); end
        n_cmp++; if (RGBOut !== 8'hFF)     begin n_err++; $display("FAIL transp_rgb got %h want ff", RGBOut); end
        n_cmp++; if (hitPulse !== 4'b0001) begin n_err++; $display("FAIL transp_hit got %b want 0001", hitPulse); end
`endif
        objDrawReq      = 4'b0000;
        boardersDrawReq = 1'b0;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        set_pix(0, 0);
        step();
        objRGB          = {8'h00, 8'h00, 8'h44, 8'h1C};
        objDrawReq      = 4'b0011;
        boardersDrawReq = 1'b1;
        set_pix(9, 9);
        step();
        step();
        n_cmp++; if (drawLayer !== 4'd0) begin n_err++; $display("FAIL mid_prelayer got %0d want 0", drawLayer); end
        #2;
        resetN = 1'b0;
        #1;
        n_cmp++; if (RGBOut !== 8'h00)       begin n_err++; $display("FAIL mid_rgb got %h want 00", RGBOut); end
        n_cmp++; if (drawLayer !== 4'd5)     begin n_err++; $display("FAIL mid_layer got %0d want 5", drawLayer); end
        n_cmp++; if (frameCount !== 8'd0)    begin n_err++; $display("FAIL mid_fc got %0d want 0", frameCount); end
        n_cmp++; if (hitPulse !== 4'b0)      begin n_err++; $display("FAIL mid_hit got %b want 0000", hitPulse); end
        objDrawReq      = 4'b0000;
        boardersDrawReq = 1'b0;
        step();
        resetN = 1'b1;
        step();
        set_pix(0, 0);
        step();
        n_cmp++; if (startOfFrame !== 1'b1)     begin n_err++; $display("FAIL mid_sof got %b want 1", startOfFrame); end
        n_cmp++; if (collisionMask !== 4'b0000) begin n_err++; $display("FAIL mid_mask got %b want 0000", collisionMask); end
        n_cmp++; if (frameCount !== 8'd1)       begin n_err++; $display("FAIL mid_fc1 got %0d want 1", frameCount); end
        set_pix(5, 5);
        step();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_frame_pulse();
        test_collision();
        test_sof_hit();
        test_transparency();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
